// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780 character-LCD driver
// Contents: FSM state enum, lcd pin positions, status word bit positions,
//           9-bit queue entry, long-executing command codes, bus base address,
//           and a constant-evaluable max helper used to size the delay counter.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT_NIB,
      ST_INIT_WAIT,
      ST_IDLE,
      ST_SETUP,
      ST_E_HIGH,
      ST_E_LOW,
      ST_EXEC_WAIT
   } lcdState_t;

   // lcd[3:0] carries D4..D7
   localparam int LCD_E_BIT  = 5;
   localparam int LCD_RS_BIT = 4;

   localparam int STAT_BUSY_BIT     = 0;
   localparam int STAT_READY_BIT    = 1;
   localparam int STAT_FULL_BIT     = 2;
   localparam int STAT_OVERFLOW_BIT = 3;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcdEntry_t;

   // Clear display and return home need the long execution wait
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   localparam logic [31:0] LCD_BASE_ADDR = 32'hF200_0000;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic isLongCmd(input lcdEntry_t e);
      return !e.rs && ((e.data == CMD_CLEAR) || (e.data == CMD_HOME));
   endfunction

endpackage

// File: rtl/lcd_fifo.sv
// rtl/lcd_fifo.sv - synchronous FIFO holding queued LCD bytes
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the queue)
//   push, pushData    write request and data; ignored while full
//   pop               read request; ignored while empty
//   popData           head entry, valid whenever empty=0
//   full, empty       occupancy flags
module lcd_fifo
   import lcd_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty when the indices match
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             doPush;
   logic             doPop;

   assign empty   = (wrPtr == rdPtr);
   assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr[AW-1:0]] <= pushData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_controller.sv
// rtl/lcd_controller.sv - memory-mapped HD44780 driver: 4-bit init sequence plus queued byte output
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   chipSelect     bus access decoded to this block
//   writeData      write at offset 0: queue dataIn[7:0] with RS=1
//   writeCommand   write at offset 4: queue dataIn[7:0] with RS=0, or clear overflow if dataIn[8]=1
//   dataIn         bus write data
//   dataOut        status {28'b0, overflow, full, ready, busy}, combinational
//   lcd            [3:0]=D4..D7, [4]=RS, [5]=E, registered
module lcd_controller
   import lcd_pkg::*;
#(
   parameter int FIFO_DEPTH        = 4,
   parameter int POWERUP_CYCLES    = 180000,
   parameter int INIT_WAIT_CYCLES  = 49200,
   parameter int E_CYCLES          = 6,
   parameter int GAP_CYCLES        = 12,
   parameter int SHORT_WAIT_CYCLES = 480,
   parameter int LONG_WAIT_CYCLES  = 19680
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipSelect,
   input  logic        writeData,
   input  logic        writeCommand,
   input  logic [31:0] dataIn,
   output logic [31:0] dataOut,
   output logic [5:0]  lcd
);

   localparam int MAX_CYCLES = maxOf(maxOf(maxOf(POWERUP_CYCLES, INIT_WAIT_CYCLES),
                                           maxOf(E_CYCLES, GAP_CYCLES)),
                                     maxOf(SHORT_WAIT_CYCLES, LONG_WAIT_CYCLES));
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);

   // Counted states load N-1 and leave when the counter reads zero, so each lasts N cycles
   function automatic logic [CNT_W-1:0] cycles(input int n);
      return CNT_W'(n - 1);
   endfunction

   lcdState_t        state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       initIdx;
   logic             initMode;
   logic             lowNibble;
   logic             ready;
   logic             overflow;
   lcdEntry_t        cur;
   lcdEntry_t        pushEntry;
   lcdEntry_t        popEntry;
   logic             full;
   logic             empty;
   logic             pop;
   logic             busy;
   logic             clearWrite;
   logic             wrReq;
   logic             unusedDataBits;

   assign clearWrite     = chipSelect && writeCommand && dataIn[8];
   assign wrReq          = chipSelect && (writeData || writeCommand) && !clearWrite;
   assign pushEntry      = '{rs: writeData, data: dataIn[7:0]};
   assign pop            = (state == ST_IDLE) && !empty;
   assign busy           = (state != ST_IDLE) || !empty;
   assign unusedDataBits = ^dataIn[31:9];

   lcd_fifo #(
      .WIDTH ($bits(lcdEntry_t)),
      .DEPTH (FIFO_DEPTH)
   ) queue (
      .clk      (clk),
      .reset    (reset),
      .push     (wrReq),
      .pushData (pushEntry),
      .pop      (pop),
      .popData  (popEntry),
      .full     (full),
      .empty    (empty)
   );

   always_comb begin
      dataOut                    = '0;
      dataOut[STAT_BUSY_BIT]     = busy;
      dataOut[STAT_READY_BIT]    = ready;
      dataOut[STAT_FULL_BIT]     = full;
      dataOut[STAT_OVERFLOW_BIT] = overflow;
   end

   // Full is sampled before any same-cycle pop, so a write on a full queue is always dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (clearWrite) begin
         overflow <= 1'b0;
      end else if (wrReq && full) begin
         overflow <= 1'b1;
      end
   end

   // Init nibbles reuse SETUP/E_HIGH/E_LOW with lowNibble forced so E_LOW exits to INIT_WAIT.
   // RS/data are only written on entry to SETUP, so they cannot move while E is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_POWERUP;
         cnt       <= cycles(POWERUP_CYCLES);
         lcd       <= '0;
         ready     <= 1'b0;
         initIdx   <= '0;
         initMode  <= 1'b0;
         lowNibble <= 1'b0;
         cur       <= '0;
      end else begin
         case (state)
            ST_POWERUP: begin
               if (cnt == '0) begin
                  state <= ST_INIT_NIB;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_INIT_NIB: begin
               lcd[LCD_E_BIT]  <= 1'b0;
               lcd[LCD_RS_BIT] <= 1'b0;
               lcd[3:0]        <= (initIdx == 2'd3) ? 4'h2 : 4'h3;
               initMode        <= 1'b1;
               lowNibble       <= 1'b1;
               cnt             <= cycles(GAP_CYCLES);
               state           <= ST_SETUP;
            end
            ST_INIT_WAIT: begin
               if (cnt == '0) begin
                  if (initIdx == 2'd3) begin
                     ready    <= 1'b1;
                     initMode <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     initIdx <= initIdx + 2'd1;
                     state   <= ST_INIT_NIB;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_IDLE: begin
               if (!empty) begin
                  cur             <= popEntry;
                  lcd[LCD_E_BIT]  <= 1'b0;
                  lcd[LCD_RS_BIT] <= popEntry.rs;
                  lcd[3:0]        <= popEntry.data[7:4];
                  lowNibble       <= 1'b0;
                  cnt             <= cycles(GAP_CYCLES);
                  state           <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == '0) begin
                  lcd[LCD_E_BIT] <= 1'b1;
                  cnt            <= cycles(E_CYCLES);
                  state          <= ST_E_HIGH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_E_HIGH: begin
               if (cnt == '0) begin
                  lcd[LCD_E_BIT] <= 1'b0;
                  cnt            <= cycles(GAP_CYCLES);
                  state          <= ST_E_LOW;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_E_LOW: begin
               if (cnt == '0) begin
                  if (!lowNibble) begin
                     lcd[3:0]  <= cur.data[3:0];
                     lowNibble <= 1'b1;
                     cnt       <= cycles(GAP_CYCLES);
                     state     <= ST_SETUP;
                  end else if (initMode) begin
                     cnt   <= cycles(INIT_WAIT_CYCLES);
                     state <= ST_INIT_WAIT;
                  end else begin
                     cnt   <= isLongCmd(cur) ? cycles(LONG_WAIT_CYCLES) : cycles(SHORT_WAIT_CYCLES);
                     state <= ST_EXEC_WAIT;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_EXEC_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_POWERUP;
               cnt   <= cycles(POWERUP_CYCLES);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_controller.sv
// tb/tb_lcd_controller.sv - scoreboard bench for lcd_controller: expected nibbles queued by the driver, checked per E pulse
module tb_lcd_controller;

   localparam int POWERUP_C = 20;
   localparam int INIT_W    = 10;
   localparam int E_CYC     = 2;
   localparam int GAP       = 3;
   localparam int SHORT_W   = 8;
   localparam int LONG_W    = 30;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipSelect;
   logic        writeData;
   logic        writeCommand;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic [5:0]  lcd;

   lcd_controller #(
      .FIFO_DEPTH        (4),
      .POWERUP_CYCLES    (POWERUP_C),
      .INIT_WAIT_CYCLES  (INIT_W),
      .E_CYCLES          (E_CYC),
      .GAP_CYCLES        (GAP),
      .SHORT_WAIT_CYCLES (SHORT_W),
      .LONG_WAIT_CYCLES  (LONG_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .chipSelect   (chipSelect),
      .writeData    (writeData),
      .writeCommand (writeCommand),
      .dataIn       (dataIn),
      .dataOut      (dataOut),
      .lcd          (lcd)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4:0] val;   // {rs, nibble}
      int         gap;   // cycles from previous E fall to this E rise, -1 = don't care
   } expNib_t;

   expNib_t expQ[$];
   int vectors     = 0;
   int miscompares = 0;
   int fallCount   = 0;
   int lastFallCyc = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic timeoutFail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out at cycle %0d, required event did not occur", name, cyc);
   endtask

   task automatic expectByte(input logic rs, input logic [7:0] b);
      expQ.push_back('{val: {rs, b[7:4]}, gap: -1});
      expQ.push_back('{val: {rs, b[3:0]}, gap: 2 * GAP});
   endtask

   task automatic expectInit();
      // Low time between init pulses: E_LOW + INIT_WAIT + INIT_NIB + SETUP
      expQ.push_back('{val: 5'h03, gap: -1});
      expQ.push_back('{val: 5'h03, gap: GAP + INIT_W + 1 + GAP});
      expQ.push_back('{val: 5'h03, gap: GAP + INIT_W + 1 + GAP});
      expQ.push_back('{val: 5'h02, gap: GAP + INIT_W + 1 + GAP});
   endtask

   task automatic busWrite(input logic isCmd, input logic [31:0] d);
      chipSelect   = 1'b1;
      writeData    = ~isCmd;
      writeCommand = isCmd;
      dataIn       = d;
      @(negedge clk);
      chipSelect   = 1'b0;
      writeData    = 1'b0;
      writeCommand = 1'b0;
      dataIn       = '0;
   endtask

   task automatic waitFalls(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (fallCount < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (fallCount < target) timeoutFail(name);
   endtask

   task automatic waitReady(input string name);
      int n;
      n = 0;
      while (!dataOut[1] && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!dataOut[1]) timeoutFail(name);
      else check({name, " ready delay"}, cyc - lastFallCyc, GAP + INIT_W);
   endtask

   task automatic waitIdle(input int waitCyc, input string name);
      int n;
      n = 0;
      while (dataOut[0] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (dataOut[0]) timeoutFail(name);
      else begin
         check({name, " exec wait"}, cyc - lastFallCyc, GAP + waitCyc);
         check({name, " idle status"}, int'(dataOut), 32'h2);
      end
   endtask

   initial begin : monitor
      logic       prevE;
      logic [4:0] prevData;
      logic [4:0] riseData;
      int         stable;
      int         riseCyc;
      expNib_t    e;
      prevE    = 1'b0;
      prevData = '0;
      riseData = '0;
      stable   = 0;
      riseCyc  = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prevE    = 1'b0;
            prevData = '0;
            stable   = 0;
         end else begin
            if (lcd[5] && !prevE) begin
               if (expQ.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected E pulse: lcd=0x%0h at cycle %0d, required no pulse", lcd, cyc);
               end else begin
                  e = expQ.pop_front();
                  check("nibble {rs,d}", int'(lcd[4:0]), int'(e.val));
                  if (e.gap >= 0) check("E low time", cyc - lastFallCyc, e.gap);
                  check("setup stable", int'((lcd[4:0] == prevData) && (stable >= GAP)), 1);
               end
               riseCyc  = cyc;
               riseData = lcd[4:0];
            end else if (lcd[5] && prevE) begin
               check("data during E", int'(lcd[4:0]), int'(riseData));
            end else if (!lcd[5] && prevE) begin
               check("E width", cyc - riseCyc, E_CYC);
               check("hold after E", int'(lcd[4:0]), int'(riseData));
               fallCount++;
               lastFallCyc = cyc;
            end
            if (!lcd[5]) stable = (lcd[4:0] == prevData) ? stable + 1 : 1;
            prevE    = lcd[5];
            prevData = lcd[4:0];
         end
      end
   end

   initial begin : driver
      int t;
      int f0;
      int n;
      chipSelect   = 1'b0;
      writeData    = 1'b0;
      writeCommand = 1'b0;
      dataIn       = '0;
      reset        = 1'b1;
      repeat (3) @(negedge clk);
      check("reset lcd", int'(lcd), 0);
      check("reset status", int'(dataOut), 32'h1);
      expectInit();
      reset = 1'b0;

      // Five writes during power-up: four fill the queue, the fifth overflows
      for (int i = 0; i < 4; i++) begin
         expectByte(1'b1, 8'h30 + 8'(i));
         busWrite(1'b0, 32'h30 + 32'(i));
      end
      check("full after 4 writes", int'(dataOut), 32'h5);
      busWrite(1'b0, 32'h34);
      check("overflow on 5th write", int'(dataOut), 32'hD);
      busWrite(1'b1, 32'h100);
      check("overflow cleared", int'(dataOut), 32'h5);
      waitFalls(4, 300, "init pulses");
      waitReady("init");
      waitIdle(SHORT_W, "bytes 0x30-0x33");

      // Data byte after ready
      expectByte(1'b1, 8'h41);
      busWrite(1'b0, 32'h41);
      check("push visible", int'(dataOut), 32'h3);
      waitIdle(SHORT_W, "data 0x41");

      // Long and short commands
      expectByte(1'b0, 8'h01);
      busWrite(1'b1, 32'h01);
      waitIdle(LONG_W, "cmd 0x01");
      expectByte(1'b0, 8'h80);
      busWrite(1'b1, 32'h80);
      waitIdle(SHORT_W, "cmd 0x80");

      // Push coinciding with an IDLE pop while two entries are queued
      f0 = fallCount;
      for (int i = 0; i < 6; i++) expectByte(1'b1, 8'h50 + 8'(i));
      for (int i = 0; i < 3; i++) busWrite(1'b0, 32'h50 + 32'(i));
      waitFalls(f0 + 2, 200, "byte 0x50 pulses");
      t = lastFallCyc;
      n = 0;
      while (cyc < t + GAP + SHORT_W && n < 100) begin
         @(negedge clk);
         n++;
      end
      busWrite(1'b0, 32'h53);
      check("count kept across push+pop", int'(dataOut), 32'h3);
      busWrite(1'b0, 32'h54);
      check("three queued", int'(dataOut), 32'h3);
      busWrite(1'b0, 32'h55);
      check("four queued full", int'(dataOut), 32'h7);
      waitIdle(SHORT_W, "bytes 0x51-0x55");

      // Reset while E is high mid-byte
      expectByte(1'b1, 8'h61);
      busWrite(1'b0, 32'h61);
      busWrite(1'b0, 32'h62);
      busWrite(1'b0, 32'h63);
      n = 0;
      while (!lcd[5] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!lcd[5]) timeoutFail("E rise before reset");
      reset = 1'b1;
      @(negedge clk);
      check("lcd after mid-byte reset", int'(lcd), 0);
      check("status after mid-byte reset", int'(dataOut), 32'h1);
      expQ.delete();
      expectInit();
      @(negedge clk);
      reset = 1'b0;
      f0 = fallCount;
      waitFalls(f0 + 4, 300, "re-init pulses");
      waitReady("re-init");
      check("queue flushed by reset", int'(dataOut), 32'h2);
      repeat (10) @(negedge clk);
      check("scoreboard drained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
